// File: rtl/uart_rx_cfg_if.sv
// Received-word handshake bundle between the UART receiver and its consumer.
// The receiver drives data and status; the consumer answers with data_ready.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;

  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: synchronised rx, mid-bit sampling, parity/framing/overrun
// flags and a one-entry holding register with valid/ready handshake.
module uart_rx_cfg #(
  parameter int CLK_SPEED = 5_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  uart_rx_cfg_if.master        rx_word,
  output logic                 overrun,
  output logic                 busy
);

  localparam int BAUD_TICK = CLK_SPEED / BAUD_RATE;
  localparam int HALF_TICK = BAUD_TICK / 2;
  localparam int CNT_W     = (BAUD_TICK > 2) ? $clog2(BAUD_TICK) : 1;
  localparam int IDX_W     = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] FULL_END = CNT_W'(BAUD_TICK - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_TICK - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic                 sync1;
  logic                 rx_s;
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 perr_acc;
  logic                 ferr_acc;

  logic sample;
  logic done;
  logic ferr_now;
  logic transfer;
  logic accept;
  logic drop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // The start bit is checked at its midpoint; later bits one full period apart.
  always_comb begin
    sample   = 1'b0;
    done     = 1'b0;
    ferr_now = ferr_acc | ~rx_s;
    if (state == S_START) begin
      sample = (cnt == HALF_END);
    end else if (state == S_DATA || state == S_PARITY || state == S_STOP) begin
      sample = (cnt == FULL_END);
    end
    if (state == S_STOP && sample && stop_idx == LAST_STOP) begin
      done = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (state == S_IDLE || state == S_WAIT_HIGH || sample) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (sample) begin
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state <= S_DATA;
              idx   <= '0;
            end
          end
        end
        S_DATA: begin
          if (sample) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (idx == LAST_IDX) begin
              state    <= (PARITY != 0) ? S_PARITY : S_STOP;
              stop_idx <= 1'b0;
              perr_acc <= 1'b0;
              ferr_acc <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (sample) begin
            perr_acc <= (PARITY == 1) ? (^shift ^ rx_s) : ~(^shift ^ rx_s);
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (sample) begin
            ferr_acc <= ferr_now;
            if (stop_idx == LAST_STOP) begin
              // A held break must return high before another start bit counts.
              state <= ferr_now ? S_WAIT_HIGH : S_IDLE;
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign transfer = rx_word.data_valid & rx_word.data_ready;
  assign accept   = done & (~rx_word.data_valid | rx_word.data_ready);
  assign drop     = done & rx_word.data_valid & ~rx_word.data_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_word.data_out   <= '0;
      rx_word.data_valid <= 1'b0;
      rx_word.parity_err <= 1'b0;
      rx_word.frame_err  <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      if (accept) begin
        rx_word.data_out   <= shift;
        rx_word.parity_err <= perr_acc;
        rx_word.frame_err  <= ferr_now;
        rx_word.data_valid <= 1'b1;
      end else if (transfer) begin
        rx_word.data_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (transfer) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
